// File: rtl/alu_arbiter.sv
// Purpose: round-robin arbiter/sequencer sharing one 4-bit ALU between NUM_REQ requesters.
// Latency: accept -> alu_valid_in 1 cycle; alu_valid_out k cycles later -> rsp_valid k+1 cycles after valid_in.
// Backpressure: one op in flight; req_ready only pulses in IDLE, requesters hold req_valid until granted.
module alu_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int CTL_W   = 4,
  parameter  int TIMEOUT = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [4*NUM_REQ-1:0]     req_a,
  input  logic [4*NUM_REQ-1:0]     req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  input  logic [CTL_W*NUM_REQ-1:0] req_ctl,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic                     alu_cin,
  output logic [CTL_W-1:0]         alu_ctl,
  output logic                     alu_valid_in,
  input  logic                     alu_valid_out,
  input  logic [3:0]               alu_result,
  input  logic                     alu_carry,
  input  logic                     alu_zero,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [3:0]               rsp_alu,
  output logic                     rsp_carry,
  output logic                     rsp_zero,
  output logic                     rsp_timeout,
  output logic                     busy,
  output logic [7:0]               stray_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    last_grant, sel, idx, cur_id;
  logic               any_req;
  logic [3:0]         op_a, op_b;
  logic               op_cin;
  logic [CTL_W-1:0]   op_ctl;
  logic [TMR_W-1:0]   timer;
  logic [3:0]         res_alu;
  logic               res_carry, res_zero, res_to;

  // Round-robin pick: first requesting index after the last one served, wrapping.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(last_grant) + i) % NUM_REQ);
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        sel     = idx;
      end
    end
  end

  // Next-state logic for the IDLE -> ISSUE -> WAIT -> RESP sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (alu_valid_out || (timer == TMR_LAST)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand latch, wait timer, result capture and grant history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      cur_id     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      op_ctl     <= '0;
      timer      <= '0;
      res_alu    <= '0;
      res_carry  <= 1'b0;
      res_zero   <= 1'b0;
      res_to     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          cur_id <= sel;
          op_a   <= req_a[4*sel +: 4];
          op_b   <= req_b[4*sel +: 4];
          op_cin <= req_cin[sel];
          op_ctl <= req_ctl[CTL_W*sel +: CTL_W];
        end
        ISSUE: timer <= '0;
        WAIT: begin
          // A result arriving on the last timer cycle still counts as a result.
          if (alu_valid_out) begin
            res_alu   <= alu_result;
            res_carry <= alu_carry;
            res_zero  <= alu_zero;
            res_to    <= 1'b0;
          end else if (timer == TMR_LAST) begin
            res_alu   <= '0;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            res_to    <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: last_grant <= cur_id;
        default: ;
      endcase
    end
  end

  // Saturating count of ALU results arriving when no op is waiting for one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stray_cnt <= '0;
    else if (alu_valid_out && (state != WAIT) && (stray_cnt != 8'hFF))
      stray_cnt <= stray_cnt + 8'd1;
  end

  // Outputs decoded from state so that reset clears them immediately.
  always_comb begin
    busy         = (state != IDLE);
    req_ready    = (reset && (state == IDLE) && any_req) ? (ONE_HOT0 << sel) : '0;
    alu_valid_in = (state == ISSUE);
    alu_a        = busy ? op_a   : '0;
    alu_b        = busy ? op_b   : '0;
    alu_cin      = busy ? op_cin : 1'b0;
    alu_ctl      = busy ? op_ctl : '0;
    rsp_valid    = (state == RESP);
    rsp_id       = rsp_valid ? cur_id    : '0;
    rsp_alu      = rsp_valid ? res_alu   : '0;
    rsp_carry    = rsp_valid ? res_carry : 1'b0;
    rsp_zero     = rsp_valid ? res_zero  : 1'b0;
    rsp_timeout  = rsp_valid ? res_to    : 1'b0;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: stub ALU with programmable response delay plus a round-robin reference model.
module tb_alu_arbiter;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam int TO = 8;

  logic            clk, rst_n;
  logic [N-1:0]    req_valid, req_cin, req_ready;
  logic [4*N-1:0]  req_a, req_b;
  logic [CW*N-1:0] req_ctl;
  logic [3:0]      alu_a, alu_b, alu_result, rsp_alu;
  logic            alu_cin, alu_valid_in, alu_valid_out, alu_carry, alu_zero;
  logic [CW-1:0]   alu_ctl;
  logic            rsp_valid, rsp_carry, rsp_zero, rsp_timeout, busy;
  logic [1:0]      rsp_id;
  logic [7:0]      stray_cnt;

  int checks = 0;
  int failures = 0;

  // requester operands
  logic [3:0]    ra [N];
  logic [3:0]    rb [N];
  logic          rcin [N];
  logic [CW-1:0] rctl [N];

  // stub ALU: ctl[0]=0 -> a+b+cin, ctl[0]=1 -> a^b; replies alu_k cycles after valid_in (0 = never)
  int alu_k = 1;
  int cd = 0;
  logic mdl_vo = 0, force_vo = 0;
  logic [3:0] m_a, m_b;
  logic m_cin;
  logic [CW-1:0] m_ctl;
  logic [4:0] m_s;
  assign alu_valid_out = mdl_vo | force_vo;

  // observations from the last transaction
  logic [N-1:0]  obs_gnt, obs_rdy;
  logic          obs_vin, obs_cin;
  logic [3:0]    obs_a, obs_b;
  logic [CW-1:0] obs_ctl;
  logic [9:0]    obs_rsp;
  int            obs_lat;
  int            lg;

  alu_arbiter #(.NUM_REQ(N), .CTL_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_ctl(req_ctl),
    .req_ready(req_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_ctl(alu_ctl), .alu_valid_in(alu_valid_in),
    .alu_valid_out(alu_valid_out), .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_alu(rsp_alu), .rsp_carry(rsp_carry),
    .rsp_zero(rsp_zero), .rsp_timeout(rsp_timeout), .busy(busy), .stray_cnt(stray_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    mdl_vo = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        if (m_ctl[0] == 1'b0) m_s = {1'b0, m_a} + {1'b0, m_b} + {4'b0, m_cin};
        else                  m_s = {1'b0, m_a ^ m_b};
        alu_result = m_s[3:0];
        alu_carry  = m_s[4];
        alu_zero   = (m_s[3:0] == 4'h0);
        mdl_vo     = 1'b1;
      end
    end
    if (alu_valid_in && alu_k > 0) begin
      cd = alu_k; m_a = alu_a; m_b = alu_b; m_cin = alu_cin; m_ctl = alu_ctl;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic int exp_grant(input logic [N-1:0] mask, input int last);
    for (int i = 1; i <= N; i++) if (mask[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  // {valid, id, alu, carry, zero, timeout} expected from requester idx's operands
  function automatic logic [9:0] exp_rsp(input int idx, input bit to);
    logic [4:0] s;
    logic [1:0] id;
    id = idx[1:0];
    if (to) return {1'b1, id, 4'h0, 1'b0, 1'b0, 1'b1};
    if (rctl[idx][0] == 1'b0) s = {1'b0, ra[idx]} + {1'b0, rb[idx]} + {4'b0, rcin[idx]};
    else                      s = {1'b0, ra[idx] ^ rb[idx]};
    return {1'b1, id, s[3:0], s[4], (s[3:0] == 4'h0), 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      ra[i] = 4'($urandom); rb[i] = 4'($urandom);
      rcin[i] = 1'($urandom); rctl[i] = CW'($urandom);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = '0; force_vo = 1'b0; alu_k = 1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Drive one request pattern until a grant, then follow the op to its response.
  task automatic do_op(input logic [N-1:0] mask, input int k);
    int n;
    alu_k = k;
    req_valid = mask;
    for (int i = 0; i < N; i++) begin
      req_a[4*i +: 4] = ra[i]; req_b[4*i +: 4] = rb[i];
      req_cin[i] = rcin[i]; req_ctl[CW*i +: CW] = rctl[i];
    end
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin tick(); #1; n++; end
    obs_gnt = req_ready;
    tick(); #1;
    obs_vin = alu_valid_in; obs_a = alu_a; obs_b = alu_b; obs_cin = alu_cin; obs_ctl = alu_ctl;
    obs_rdy = req_ready;
    obs_lat = 0;
    while (!rsp_valid && obs_lat < 40) begin tick(); #1; obs_lat++; end
    obs_rsp = {rsp_valid, rsp_id, rsp_alu, rsp_carry, rsp_zero, rsp_timeout};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; req_ctl = '0;
    #2;
    checks++;
    if ({req_ready, alu_a, alu_b, alu_cin, alu_ctl, alu_valid_in, rsp_valid, rsp_id, rsp_alu,
         rsp_carry, rsp_zero, rsp_timeout, busy, stray_cnt} !== '0) begin
      failures++; $display("FAIL reset_outputs got busy=%b vin=%b rsp=%b stray=%0d exp=all zero",
                           busy, alu_valid_in, rsp_valid, stray_cnt);
    end
    apply_reset();
  endtask

  task automatic test_single();
    ra[0] = 4'h9; rb[0] = 4'h8; rcin[0] = 1'b0; rctl[0] = 4'h0;
    do_op(4'b0001, 1);
    req_valid = '0;
    checks++; if (obs_gnt !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", obs_gnt); end
    checks++;
    if ({obs_vin, obs_a, obs_b, obs_cin, obs_ctl, obs_rdy} !== {1'b1, 4'h9, 4'h8, 1'b0, 4'h0, 4'b0000}) begin
      failures++; $display("FAIL single_issue got vin=%b a=%h b=%h cin=%b ctl=%h rdy=%b exp 1 9 8 0 0 0000",
                           obs_vin, obs_a, obs_b, obs_cin, obs_ctl, obs_rdy);
    end
    checks++; if (obs_lat !== 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", obs_lat); end
    checks++;
    if (obs_rsp !== 10'b1_00_0001_1_0_0) begin failures++; $display("FAIL single_rsp got=%b exp=1000001100", obs_rsp); end
    tick(); #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_alu, rsp_carry, busy} !== '0) begin
      failures++; $display("FAIL single_after_rsp got valid=%b alu=%h busy=%b exp=0", rsp_valid, rsp_alu, busy);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    rand_ops();
    for (int op = 0; op < 8; op++) begin
      do_op(4'b1111, int'($urandom_range(1, 3)));
      checks++;
      if (obs_gnt !== (4'b0001 << (op % N))) begin
        failures++; $display("FAIL rr_grant op=%0d got=%b exp=%b", op, obs_gnt, 4'b0001 << (op % N));
      end
      checks++;
      if (obs_rsp !== exp_rsp(op % N, 1'b0)) begin
        failures++; $display("FAIL rr_rsp op=%0d got=%b exp=%b", op, obs_rsp, exp_rsp(op % N, 1'b0));
      end
      ra[op % N] = 4'($urandom);
    end
    req_valid = '0;
    lg = N - 1;
  endtask

  task automatic test_wrap();
    int exp_order [3] = '{2, 3, 1};
    logic [N-1:0] masks [3] = '{4'b0100, 4'b1010, 4'b1010};
    for (int t = 0; t < 3; t++) begin
      rand_ops();
      do_op(masks[t], 2);
      checks++;
      if (obs_gnt !== (4'b0001 << exp_order[t])) begin
        failures++; $display("FAIL wrap_grant step=%0d got=%b exp=%b", t, obs_gnt, 4'b0001 << exp_order[t]);
      end
      checks++;
      if (obs_rsp !== exp_rsp(exp_order[t], 1'b0)) begin
        failures++; $display("FAIL wrap_rsp step=%0d got=%b exp=%b", t, obs_rsp, exp_rsp(exp_order[t], 1'b0));
      end
    end
    req_valid = '0;
    lg = 1;
  endtask

  task automatic test_timeout();
    int ks [3] = '{0, TO, 1};
    logic [N-1:0] masks [3] = '{4'b0001, 4'b0010, 4'b0100};
    for (int t = 0; t < 3; t++) begin
      rand_ops();
      rctl[t] = 4'h0; ra[t] = 4'h0; rb[t] = 4'h0; rcin[t] = 1'b0;
      do_op(masks[t], ks[t]);
      checks++;
      if (obs_lat !== ((ks[t] == 0) ? TO + 1 : ks[t] + 1)) begin
        failures++; $display("FAIL timeout_latency k=%0d got=%0d exp=%0d", ks[t], obs_lat,
                             (ks[t] == 0) ? TO + 1 : ks[t] + 1);
      end
      checks++;
      if (obs_rsp !== exp_rsp(t, ks[t] == 0)) begin
        failures++; $display("FAIL timeout_rsp k=%0d got=%b exp=%b", ks[t], obs_rsp, exp_rsp(t, ks[t] == 0));
      end
    end
    req_valid = '0;
    lg = 2;
  endtask

  task automatic test_stray();
    logic seen;
    apply_reset();
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      force_vo = 1'b1; tick(); seen |= rsp_valid;
      force_vo = 1'b0; tick(); seen |= rsp_valid;
    end
    #1;
    checks++; if (stray_cnt !== 8'd3) begin failures++; $display("FAIL stray_three got=%0d exp=3", stray_cnt); end
    force_vo = 1'b1;
    for (int i = 0; i < 300; i++) begin tick(); seen |= rsp_valid | busy; end
    force_vo = 1'b0;
    tick(); #1;
    checks++; if (stray_cnt !== 8'd255) begin failures++; $display("FAIL stray_saturate got=%0d exp=255", stray_cnt); end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL stray_no_rsp got=%b exp=0", seen); end
  endtask

  task automatic test_reset_mid_op();
    logic seen;
    rand_ops();
    alu_k = 0;
    req_valid = 4'b0001;
    tick(); req_valid = '0;
    tick(); tick(); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    req_valid = 4'b0001;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({alu_valid_in, busy, rsp_valid, req_ready, alu_a, alu_b, alu_ctl, stray_cnt} !== '0) begin
      failures++; $display("FAIL midrst_outputs got vin=%b busy=%b rsp=%b rdy=%b a=%h stray=%0d exp=0",
                           alu_valid_in, busy, rsp_valid, req_ready, alu_a, stray_cnt);
    end
    seen = 1'b0;
    repeat (3) begin tick(); seen |= rsp_valid; end
    req_valid = '0;
    rst_n = 1'b1;
    tick(); seen |= rsp_valid;
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_no_rsp got=%b exp=0", seen); end
    do_op(4'b1111, 2);
    req_valid = '0;
    checks++; if (obs_gnt !== 4'b0001) begin failures++; $display("FAIL midrst_first_grant got=%b exp=0001", obs_gnt); end
    checks++;
    if (obs_rsp !== exp_rsp(0, 1'b0)) begin failures++; $display("FAIL midrst_rsp got=%b exp=%b", obs_rsp, exp_rsp(0, 1'b0)); end
    lg = 0;
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    int k, g;
    for (int op = 0; op < 24; op++) begin
      rand_ops();
      mask = N'($urandom_range(1, (1 << N) - 1));
      k = int'($urandom_range(0, TO));
      g = exp_grant(mask, lg);
      do_op(mask, k);
      checks++;
      if (obs_gnt !== (4'b0001 << g)) begin
        failures++; $display("FAIL rand_grant op=%0d mask=%b got=%b exp=%b", op, mask, obs_gnt, 4'b0001 << g);
      end
      checks++;
      if (obs_lat !== ((k == 0) ? TO + 1 : k + 1)) begin
        failures++; $display("FAIL rand_latency op=%0d k=%0d got=%0d exp=%0d", op, k, obs_lat, (k == 0) ? TO + 1 : k + 1);
      end
      checks++;
      if (obs_rsp !== exp_rsp(g, k == 0)) begin
        failures++; $display("FAIL rand_rsp op=%0d got=%b exp=%b", op, obs_rsp, exp_rsp(g, k == 0));
      end
      lg = g;
    end
    req_valid = '0;
    tick(); #1;
    checks++; if (stray_cnt !== 8'd0) begin failures++; $display("FAIL rand_no_stray got=%0d exp=0", stray_cnt); end
  endtask

  initial begin
    force_vo = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_stray();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single 4-bit ALU between NUM_REQ requesters.
- Accepts one operation at a time and drives the ALU's a/b/cin/ctl/valid_in.
- Waits for the ALU's valid_out, or times out, then returns alu/carry/zero to the requester that issued it, tagged with the requester index.
- Sits between the requester-side logic and the ALU inside the ALU subsystem.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CTL_W, 4, width of the opcode field (matches ALU ctl)
TIMEOUT, 8, WAIT cycles without alu_valid_out before the op is aborted (≥2)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operation request
req_a  in  4*NUM_REQ  operand A, requester i at bits [4i+3:4i]
req_b  in  4*NUM_REQ  operand B, same packing
req_cin  in  NUM_REQ  carry-in per requester
req_ctl  in  CTL_W*NUM_REQ  opcode per requester
req_ready  out  NUM_REQ  one-hot accept pulse
alu_a  out  4  to ALU a
alu_b  out  4  to ALU b
alu_cin  out  1  to ALU cin
alu_ctl  out  CTL_W  to ALU ctl
alu_valid_in  out  1  to ALU valid_in
alu_valid_out  in  1  from ALU valid_out
alu_result  in  4  from ALU alu
alu_carry  in  1  from ALU carry
alu_zero  in  1  from ALU zero
rsp_valid  out  1  one-cycle response pulse
rsp_id  out  $clog2(NUM_REQ)  requester index of the response
rsp_alu  out  4  result
rsp_carry  out  1  carry
rsp_zero  out  1  zero
rsp_timeout  out  1  response is a timeout abort
busy  out  1  high in any state except IDLE
stray_cnt  out  8  saturating count of alu_valid_out seen outside WAIT

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all outputs 0.
  - last_grant=NUM_REQ-1, so requester 0 has top priority first.
  - Timer=0, stray_cnt=0.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid, select the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Assert req_ready[sel] combinationally in this cycle; requester i's op is accepted when req_valid[i] && req_ready[i].
  - Latch a/b/cin/ctl/sel at the edge; go to ISSUE.
  - No req_valid: stay, req_ready=0.
- ISSUE:
  - alu_valid_in=1 for exactly one cycle with the latched operands; go to WAIT, timer=0.
  - req_ready=0 in every state except IDLE.
- WAIT:
  - alu_valid_in=0; alu_a/b/cin/ctl hold the latched values until IDLE.
  - alu_valid_out=1: capture alu_result/carry/zero, go to RESP, timeout flag=0.
  - Otherwise timer++. If timer reaches TIMEOUT-1 without valid_out, go to RESP with the timeout flag set and the result fields forced to 0.
  - If valid_out arrives in the same cycle the timer expires, valid_out wins (no timeout).
- RESP:
  - rsp_valid=1 for one cycle; rsp_id/rsp_alu/rsp_carry/rsp_zero/rsp_timeout are valid only while rsp_valid=1 and are 0 otherwise.
  - last_grant=rsp_id; go to IDLE.
- Latency: accept edge to alu_valid_in is 1 cycle. With an ALU valid_out k cycles after valid_in (k≥1), rsp_valid is asserted k+1 cycles after alu_valid_in. Minimum request-to-request spacing is 4 cycles.
- stray_cnt increments on alu_valid_out=1 in IDLE, ISSUE or RESP; saturates at 255; cleared only by reset.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
- Requests dropped before acceptance are simply never granted. Requests are not queued; requesters hold req_valid until req_ready.
- Reset mid-operation: the op is abandoned with no rsp_valid, and the ALU sees valid_in drop immediately.
- Operands/opcode pass through unmodified; widths are fixed at 4-bit data and CTL_W opcode; no arithmetic in this block.

Test Plan:
1. Single request: req_valid=4'b0001, a=4'h9, b=4'h8, cin=0, ADD; ALU responds k=1 -> req_ready[0] pulse, alu_valid_in 1 cycle later, rsp_valid 2 cycles after alu_valid_in with rsp_id=0, rsp_alu=4'h1, rsp_carry=1, rsp_zero=0.
2. All requesters held high for 8 ops -> grant order 0,1,2,3,0,1,2,3; exactly one req_ready bit per grant.
3. Requesters 1 and 3 active after a grant to 2 -> 3 is granted before 1 (wrap-around priority).
4. ALU never asserts valid_out -> rsp_valid 1 cycle after timer reaches TIMEOUT-1 (TIMEOUT=8) with rsp_timeout=1 and rsp_alu/carry/zero=0; next request then proceeds normally.
5. Pulse alu_valid_out in IDLE 3 times and 300 times -> stray_cnt=3, then saturates at 255; no rsp_valid generated.
6. Assert reset low during WAIT -> all outputs 0 immediately, no rsp_valid, busy=0. After release, requester 0 wins when all four request.
